line_window_gen: RTL and testbench

Parametrised line-buffer and window generator: the next generation of the fixed 3-line, 512-pixel, 8-bit front end of the convolution datapath in `ip_top`. It stores NUM_LINES image rows in a circular bank and emits one KERNELxKERNEL pixel window per output pixel, clamping at the left and right borders. Output uses a valid/ready handshake, and input uses ready backpressure. It pulses an interrupt each time a row slot is released, so the host DMA can refill one line at a time.

---
 rtl/line_window_gen.sv | 159 +++++++++++++++
 tb/tb_line_window_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_gen.sv
// line_window_gen: circular bank of image rows feeding a KERNELxKERNEL
// window generator with border replication and a valid/ready output.
module line_window_gen #(
    parameter int DATA_W    = 8,
    parameter int IMG_WIDTH = 512,
    parameter int KERNEL    = 3,
    parameter int NUM_LINES = 4
) (
    input  logic                             axi_clk,
    input  logic                             axi_rst,
    input  logic                             i_clear,
    input  logic                             i_data_valid,
    input  logic [DATA_W-1:0]                i_data,
    output logic                             o_data_ready,
    output logic                             o_window_valid,
    output logic [KERNEL*KERNEL*DATA_W-1:0]  o_window,
    input  logic                             i_window_ready,
    output logic                             intr,
    output logic [$clog2(NUM_LINES+1)-1:0]   o_lines_filled
);

    localparam int H  = (KERNEL - 1) / 2;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int LW = $clog2(NUM_LINES);
    localparam int FW = $clog2(NUM_LINES + 1);
    localparam int WW = KERNEL * KERNEL * DATA_W;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    logic [DATA_W-1:0] mem [NUM_LINES][IMG_WIDTH];

    state_t          state;
    logic [CW-1:0]   wr_col;
    logic [LW-1:0]   wr_line;
    logic [CW-1:0]   rd_col;
    logic [LW-1:0]   rd_line;
    logic [FW-1:0]   lines_filled;
    logic [FW-1:0]   lf_next;
    logic [WW-1:0]   win_next;
    logic            accept;
    logic            row_done;
    logic            rel_line;
    int              sel;
    int              slot;
    int              col;

    assign accept   = i_data_valid && o_data_ready;
    assign row_done = accept && (wr_col == CW'(IMG_WIDTH - 1));
    assign rel_line = (state == RUN) && o_window_valid && i_window_ready
                      && (rd_col == CW'(IMG_WIDTH - 1));

    assign o_data_ready   = (lines_filled < FW'(NUM_LINES));
    assign o_lines_filled = lines_filled;

    // Row count after this edge: completion and release cancel out.
    always_comb begin
        lf_next = lines_filled;
        if (row_done && !rel_line)
            lf_next = lines_filled + FW'(1);
        else if (!row_done && rel_line)
            lf_next = lines_filled - FW'(1);
    end

    // Window for the column about to be loaded: the current one when
    // nothing is held, otherwise the next one after a transfer.
    always_comb begin
        win_next = '0;
        sel      = int'(rd_col);
        slot     = 0;
        col      = 0;
        if (o_window_valid)
            sel = sel + 1;
        for (int r = 0; r < KERNEL; r++) begin
            slot = int'(rd_line) + r;
            if (slot >= NUM_LINES)
                slot = slot - NUM_LINES;
            for (int k = 0; k < KERNEL; k++) begin
                col = sel + k - H;
                if (col < 0)
                    col = 0;
                if (col > IMG_WIDTH - 1)
                    col = IMG_WIDTH - 1;
                win_next[(r*KERNEL+k)*DATA_W +: DATA_W] =
                    mem[LW'(slot)][CW'(col)];
            end
        end
    end

    // Pixel storage; contents need no reset.
    always_ff @(posedge axi_clk) begin
        if (accept)
            mem[wr_line][wr_col] <= i_data;
    end

    // Write pointers, row accounting and the read FSM.
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            state          <= IDLE;
            wr_col         <= '0;
            wr_line        <= '0;
            rd_col         <= '0;
            rd_line        <= '0;
            lines_filled   <= '0;
            o_window_valid <= 1'b0;
            o_window       <= '0;
            intr           <= 1'b0;
        end else if (i_clear) begin
            state          <= IDLE;
            wr_col         <= '0;
            wr_line        <= '0;
            rd_col         <= '0;
            rd_line        <= '0;
            lines_filled   <= '0;
            o_window_valid <= 1'b0;
            o_window       <= '0;
            intr           <= 1'b0;
        end else begin
            intr         <= rel_line;
            lines_filled <= lf_next;
            if (accept) begin
                if (wr_col == CW'(IMG_WIDTH - 1)) begin
                    wr_col  <= '0;
                    wr_line <= (wr_line == LW'(NUM_LINES - 1)) ?
                               '0 : wr_line + LW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (lines_filled >= FW'(KERNEL))
                        state <= RUN;
                end
                RUN: begin
                    if (!o_window_valid) begin
                        o_window       <= win_next;
                        o_window_valid <= 1'b1;
                    end else if (i_window_ready) begin
                        if (rd_col == CW'(IMG_WIDTH - 1)) begin
                            o_window_valid <= 1'b0;
                            rd_col         <= '0;
                            rd_line        <= (rd_line == LW'(NUM_LINES - 1)) ?
                                              '0 : rd_line + LW'(1);
                            state          <= (lf_next >= FW'(KERNEL)) ?
                                              RUN : IDLE;
                        end else begin
                            rd_col   <= rd_col + CW'(1);
                            o_window <= win_next;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Bench for line_window_gen: scoreboard of windows derived from the
// pixel pattern row*16+col, random valid/ready timing, K=3 and K=5.
module tb_line_window_gen;

    localparam int W = 8;
    localparam logic [71:0] C0 = {8'h21, 8'h20, 8'h20, 8'h11, 8'h10,
                                  8'h10, 8'h01, 8'h00, 8'h00};
    localparam logic [71:0] C7 = {8'h27, 8'h27, 8'h26, 8'h17, 8'h17,
                                  8'h16, 8'h07, 8'h07, 8'h06};

    logic clk;
    logic rst;

    logic         i_clear3;
    logic         i_data_valid3;
    logic [7:0]   i_data3;
    logic         o_data_ready3;
    logic         o_window_valid3;
    logic [71:0]  o_window3;
    logic         i_window_ready3;
    logic         intr3;
    logic [2:0]   o_lines_filled3;

    logic         i_clear5;
    logic         i_data_valid5;
    logic [7:0]   i_data5;
    logic         o_data_ready5;
    logic         o_window_valid5;
    logic [199:0] o_window5;
    logic         i_window_ready5;
    logic         intr5;
    logic [2:0]   o_lines_filled5;

    int checks = 0;
    int errors = 0;

    int p3 = 0;
    int p5 = 0;

    logic [199:0] q3[$];
    logic [199:0] q5[$];
    int m_lf3 = 0, m_rows3 = 0, m_wcol3 = 0, m_xfer3 = 0, m_rel3 = 0;
    int m_lf5 = 0, m_rows5 = 0, m_wcol5 = 0, m_xfer5 = 0, m_rel5 = 0;
    bit m_intr3 = 0, m_intr5 = 0;
    int intr_cnt3 = 0, intr_cnt5 = 0;

    line_window_gen #(
        .DATA_W(8), .IMG_WIDTH(W), .KERNEL(3), .NUM_LINES(4)
    ) dut3 (
        .axi_clk        (clk),
        .axi_rst        (rst),
        .i_clear        (i_clear3),
        .i_data_valid   (i_data_valid3),
        .i_data         (i_data3),
        .o_data_ready   (o_data_ready3),
        .o_window_valid (o_window_valid3),
        .o_window       (o_window3),
        .i_window_ready (i_window_ready3),
        .intr           (intr3),
        .o_lines_filled (o_lines_filled3)
    );

    line_window_gen #(
        .DATA_W(8), .IMG_WIDTH(W), .KERNEL(5), .NUM_LINES(6)
    ) dut5 (
        .axi_clk        (clk),
        .axi_rst        (rst),
        .i_clear        (i_clear5),
        .i_data_valid   (i_data_valid5),
        .i_data         (i_data5),
        .o_data_ready   (o_data_ready5),
        .o_window_valid (o_window_valid5),
        .o_window       (o_window5),
        .i_window_ready (i_window_ready5),
        .intr           (intr5),
        .o_lines_filled (o_lines_filled5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int row, input int c);
        return 8'((row * 16 + c) & 255);
    endfunction

    function automatic logic [199:0] exp_win(input int k, input int line,
                                             input int col);
        logic [199:0] w = '0;
        int h = (k - 1) / 2;
        for (int r = 0; r < k; r++) begin
            for (int j = 0; j < k; j++) begin
                int c = col + j - h;
                if (c < 0) c = 0;
                if (c > W - 1) c = W - 1;
                w[(r*k+j)*8 +: 8] = pix(line + r, c);
            end
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [199:0] act,
                         input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive3(input bit v, input bit r);
        i_data3         = pix(p3 / W, p3 % W);
        i_data_valid3   = v;
        i_window_ready3 = r;
        if (v && o_data_ready3) p3++;
    endtask

    task automatic drive5(input bit v, input bit r);
        i_data5         = pix(p5 / W, p5 % W);
        i_data_valid5   = v;
        i_window_ready5 = r;
        if (v && o_data_ready5) p5++;
    endtask

    task automatic write_rows3(input int rows, input bit rnd);
        int n = 0;
        while (p3 < rows * W && n < 2000) begin
            tick();
            drive3(rnd ? (($urandom % 4) != 0) : 1'b1,
                   rnd ? 1'($urandom % 2) : 1'b0);
            n++;
        end
        check("write3_done", 200'(p3), 200'(rows * W));
    endtask

    task automatic write_rows5(input int rows, input bit rnd);
        int n = 0;
        while (p5 < rows * W && n < 2000) begin
            tick();
            drive5(rnd ? (($urandom % 4) != 0) : 1'b1,
                   rnd ? 1'($urandom % 2) : 1'b0);
            n++;
        end
        check("write5_done", 200'(p5), 200'(rows * W));
    endtask

    always @(negedge clk) begin
        logic [199:0] e;
        if (!rst) begin
            check("lf3", 200'(o_lines_filled3), 200'(m_lf3));
            check("rdy3", 200'(o_data_ready3), 200'(m_lf3 < 4));
            check("intr3", 200'(intr3), 200'(m_intr3));
            if (intr3) intr_cnt3++;
            m_intr3 = 0;
            if (i_clear3) begin
                q3.delete();
                m_lf3 = 0; m_rows3 = 0; m_wcol3 = 0;
                m_xfer3 = 0; m_rel3 = 0;
            end else begin
                if (i_data_valid3 && o_data_ready3) begin
                    m_wcol3++;
                    if (m_wcol3 == W) begin
                        m_wcol3 = 0;
                        m_rows3++;
                        m_lf3++;
                        if (m_rows3 >= 3)
                            for (int c = 0; c < W; c++)
                                q3.push_back(exp_win(3, m_rows3 - 3, c));
                    end
                end
                if (o_window_valid3 && i_window_ready3) begin
                    e = (q3.size() == 0) ? '1 : q3.pop_front();
                    check("win3", 200'(o_window3), e);
                    if (m_rel3 == 0 && m_xfer3 == 0)
                        check("win3_c0", 200'(o_window3), 200'(C0));
                    if (m_rel3 == 0 && m_xfer3 == W - 1)
                        check("win3_c7", 200'(o_window3), 200'(C7));
                    m_xfer3++;
                    if (m_xfer3 == W) begin
                        m_xfer3 = 0;
                        m_rel3++;
                        m_lf3--;
                        m_intr3 = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [199:0] e;
        if (!rst) begin
            check("lf5", 200'(o_lines_filled5), 200'(m_lf5));
            check("rdy5", 200'(o_data_ready5), 200'(m_lf5 < 6));
            check("intr5", 200'(intr5), 200'(m_intr5));
            if (intr5) intr_cnt5++;
            m_intr5 = 0;
            if (i_data_valid5 && o_data_ready5) begin
                m_wcol5++;
                if (m_wcol5 == W) begin
                    m_wcol5 = 0;
                    m_rows5++;
                    m_lf5++;
                    if (m_rows5 >= 5)
                        for (int c = 0; c < W; c++)
                            q5.push_back(exp_win(5, m_rows5 - 5, c));
                end
            end
            if (o_window_valid5 && i_window_ready5) begin
                e = (q5.size() == 0) ? '1 : q5.pop_front();
                check("win5", o_window5, e);
                m_xfer5++;
                if (m_xfer5 == W) begin
                    m_xfer5 = 0;
                    m_rel5++;
                    m_lf5--;
                    m_intr5 = 1;
                end
            end
        end
    end

    initial begin
        int n;
        bit tog;
        rst = 1'b1;
        i_clear3 = 0; i_data_valid3 = 0; i_data3 = 0; i_window_ready3 = 0;
        i_clear5 = 0; i_data_valid5 = 0; i_data5 = 0; i_window_ready5 = 0;
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 200'(o_window_valid3), 200'(0));
        check("rst_window", 200'(o_window3), 200'(0));
        check("rst_intr", 200'(intr3), 200'(0));
        check("rst_lf", 200'(o_lines_filled3), 200'(0));
        check("rst_ready", 200'(o_data_ready3), 200'(1));
        check("rst_valid5", 200'(o_window_valid5), 200'(0));
        rst = 1'b0;

        write_rows3(3, 0);
        n = 0;
        while (!o_window_valid3 && n < 30) begin
            tick(); drive3(0, 0); n++;
        end
        check("first_valid3", 200'(o_window_valid3), 200'(1));
        @(negedge clk);
        check("first_win3", 200'(o_window3), 200'(C0));

        write_rows3(4, 0);
        tick(); drive3(0, 0);
        @(negedge clk);
        check("full_ready3", 200'(o_data_ready3), 200'(0));
        repeat (5) begin tick(); drive3(1, 0); end
        tick(); drive3(0, 0);
        @(negedge clk);
        check("held_win3", 200'(o_window3), 200'(C0));
        check("held_lf3", 200'(o_lines_filled3), 200'(4));
        check("held_p3", 200'(p3), 200'(4 * W));

        n = 0; tog = 1;
        while (m_rel3 < 1 && n < 100) begin
            tick(); drive3(0, tog); tog = !tog; n++;
        end
        check("line0_done", 200'(m_rel3), 200'(1));

        while (p3 < 4 * W + 7) begin tick(); drive3(1, 0); end
        n = 0;
        tick(); drive3(0, 0);
        while (!(o_window_valid3 && m_xfer3 == W - 1) && n < 100) begin
            tick(); drive3(0, o_window_valid3 && m_xfer3 < W - 1); n++;
        end
        check("line1_at_c7", 200'(m_xfer3), 200'(W - 1));
        tick(); drive3(1, 1);
        tick(); drive3(0, 0);
        @(negedge clk);
        check("same_cycle_lf", 200'(o_lines_filled3), 200'(3));
        check("same_cycle_rel", 200'(m_rel3), 200'(2));

        write_rows3(12, 1);
        n = 0;
        while (m_rel3 < 10 && n < 1000) begin
            tick(); drive3(0, 1'($urandom % 2)); n++;
        end
        tick(); drive3(0, 0);
        tick();
        @(negedge clk);
        check("intr_count3", 200'(intr_cnt3), 200'(10));
        check("drain_lf3", 200'(o_lines_filled3), 200'(2));
        check("drain_q3", 200'(q3.size()), 200'(0));

        write_rows3(13, 0);
        n = 0;
        tick(); drive3(0, 0);
        while (!(o_window_valid3 && m_xfer3 == 4) && n < 100) begin
            tick(); drive3(0, o_window_valid3 && m_xfer3 < 4); n++;
        end
        check("clear_at_c4", 200'(m_xfer3), 200'(4));
        tick(); i_clear3 = 1; drive3(0, 0);
        tick(); i_clear3 = 0; p3 = 0; drive3(0, 0);
        @(negedge clk);
        check("clear_valid", 200'(o_window_valid3), 200'(0));
        check("clear_lf", 200'(o_lines_filled3), 200'(0));
        check("clear_intr", 200'(intr3), 200'(0));

        write_rows3(3, 1);
        n = 0;
        while (m_rel3 < 1 && n < 200) begin
            tick(); drive3(0, 1'($urandom % 2)); n++;
        end
        tick(); drive3(0, 0);
        tick();
        @(negedge clk);
        check("fresh_line", 200'(m_rel3), 200'(1));
        check("fresh_q3", 200'(q3.size()), 200'(0));

        write_rows5(5, 0);
        n = 0;
        while (!o_window_valid5 && n < 30) begin
            tick(); drive5(0, 0); n++;
        end
        check("first_valid5", 200'(o_window_valid5), 200'(1));
        @(negedge clk);
        check("first_row5", 200'(o_window5[39:0]), 200'(40'h0201000000));
        write_rows5(7, 1);
        n = 0;
        while (m_rel5 < 3 && n < 1000) begin
            tick(); drive5(0, 1'($urandom % 2)); n++;
        end
        tick(); drive5(0, 0);
        tick();
        @(negedge clk);
        check("intr_count5", 200'(intr_cnt5), 200'(3));
        check("drain_q5", 200'(q5.size()), 200'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
